// File: rtl/instr_mem_bank_pkg.sv
// Shared constants for the banked instruction memory: NOP word, boot FSM states
// and the boot image copied into bank 0 after reset.
package instr_mem_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'hF800_0000;
    localparam int          BOOT_IMAGE_LEN = 22;

    typedef enum logic {
        BOOT,
        READY
    } boot_state_t;

    // Words 0-9 emit the process-output sequence, 10-13 set up SO/SOi, and
    // 14-21 form the hdload/storeso loop that pulls process programs in.
    function automatic logic [31:0] boot_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h5000_0000;
            1:       w = 32'h6040_000C;
            2:       w = 32'h6080_0001;
            3:       w = 32'h8840_0000;
            4:       w = 32'h6040_000D;
            5:       w = 32'h8840_0000;
            6:       w = 32'h6040_000E;
            7:       w = 32'h8840_0000;
            8:       w = 32'h6040_000F;
            9:       w = 32'h8840_0000;
            10:      w = 32'h60C0_0000;
            11:      w = 32'h6100_0001;
            12:      w = 32'h6140_0100;
            13:      w = 32'h6180_0000;
            14:      w = 32'hA1C3_0000;
            15:      w = 32'hA9C4_0000;
            16:      w = 32'h0861_0000;
            17:      w = 32'h0902_0000;
            18:      w = 32'h3043_4000;
            19:      w = 32'hD000_000E;
            20:      w = 32'hB000_0000;
            21:      w = 32'hC800_0000;
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_mem_bank_boot_fsm.sv
// Boot sequencer: after reset streams the boot image into bank 0, one word per
// falling clock edge, then holds READY until the next reset.
module instr_mem_boot_fsm
    import instr_mem_pkg::*;
#(
    parameter int data_size   = 32,
    parameter int memory_size = 11,
    parameter int boot_len    = 22
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    output logic                   o_boot_we,
    output logic [memory_size-1:0] o_boot_addr,
    output logic [data_size-1:0]   o_boot_data,
    output logic                   o_boot_last,
    output logic                   o_ready
);

    localparam logic [memory_size-1:0] LAST_IDX = memory_size'(boot_len - 1);

    boot_state_t            r_state;
    logic [memory_size-1:0] r_idx;
    logic                   r_ready;

    always_ff @(negedge i_clk) begin
        if (i_srst) begin
            r_state <= BOOT;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_idx <= r_idx + memory_size'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                READY: r_ready <= 1'b1;
            endcase
        end
    end

    // Gated by reset so nothing is copied while reset is held.
    assign o_boot_we   = (r_state == BOOT) && !i_srst;
    assign o_boot_last = o_boot_we && (r_idx == LAST_IDX);
    assign o_boot_addr = r_idx;
    assign o_boot_data = data_size'(boot_word(int'(r_idx)));
    assign o_ready     = r_ready;

endmodule

// File: rtl/instr_mem_bank.sv
// Banked, writable instruction memory with per-bank fetch limits and a boot copy
// into bank 0. Define INSTR_MEM_BYPASS_EN for same-edge write-to-fetch forwarding.
module instr_mem_bank
    import instr_mem_pkg::*;
#(
    parameter int data_size   = 32,
    parameter int memory_size = 11,
    parameter int num_proc    = 4,
    parameter int proc_w      = 2,
    parameter int boot_len    = 22
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [proc_w-1:0]      proc_sel,
    input  logic [memory_size-1:0] end_c,
    input  logic                   rd_en,
    output logic [data_size-1:0]   instruction_out,
    output logic                   instr_valid,
    output logic                   fault_out,
    input  logic                   wr_en,
    input  logic [proc_w-1:0]      wr_proc,
    input  logic [memory_size-1:0] end_save,
    input  logic [data_size-1:0]   data_in,
    input  logic                   clr_en,
    output logic                   ready_out
);

    localparam int                   AW         = proc_w + memory_size;
    localparam logic [memory_size:0] BOOT_LIMIT = (memory_size + 1)'(boot_len);
    localparam logic [data_size-1:0] NOP_WORD   = data_size'(NOP_INSTR);

    logic                   w_boot_we;
    logic                   w_boot_last;
    logic [memory_size-1:0] w_boot_addr;
    logic [data_size-1:0]   w_boot_data;
    logic                   w_ready;
    logic                   w_proc_ok;
    logic                   w_wr_ok;
    logic                   w_user_we;
    logic                   w_fetch;
    logic                   w_fault;
    logic                   w_in_limit;
    logic [memory_size:0]   w_new_limit;
    logic [memory_size:0]   w_rd_limit;
    logic                   w_we;
    logic [AW-1:0]          w_waddr;
    logic [data_size-1:0]   w_wdata;

    logic [num_proc-1:0][memory_size:0] w_limit;

    logic [data_size-1:0] r_mem [0:(2**AW)-1];
    logic [data_size-1:0] r_rd_data;
    logic                 r_valid;
    logic                 r_fault;
    logic                 r_nop;

    instr_mem_boot_fsm #(
        .data_size  (data_size),
        .memory_size(memory_size),
        .boot_len   (boot_len)
    ) u_boot_fsm (
        .i_clk      (clock_in),
        .i_srst     (reset_in),
        .o_boot_we  (w_boot_we),
        .o_boot_addr(w_boot_addr),
        .o_boot_data(w_boot_data),
        .o_boot_last(w_boot_last),
        .o_ready    (w_ready)
    );

    // Selectors can only name a missing bank when num_proc is not a power of two.
    generate
        if (num_proc >= (1 << proc_w)) begin : g_full_sel
            assign w_proc_ok = 1'b1;
            assign w_wr_ok   = 1'b1;
        end else begin : g_part_sel
            assign w_proc_ok = {1'b0, proc_sel} < (proc_w + 1)'(num_proc);
            assign w_wr_ok   = {1'b0, wr_proc} < (proc_w + 1)'(num_proc);
        end
    endgenerate

    assign w_user_we   = w_ready && wr_en && !clr_en && w_wr_ok;
    assign w_fetch     = w_ready && rd_en;
    assign w_new_limit = {1'b0, end_save} + (memory_size + 1)'(1);

    generate
        for (genvar gi = 0; gi < num_proc; gi++) begin : g_bank
            localparam bit IS_BOOT_BANK = (gi == 0);
            logic                 w_sel;
            logic [memory_size:0] r_limit;

            assign w_sel = (wr_proc == proc_w'(gi));

            always_ff @(negedge clock_in) begin
                if (reset_in) begin
                    r_limit <= '0;
                end else if (IS_BOOT_BANK && w_boot_last) begin
                    r_limit <= BOOT_LIMIT;
                end else if (w_ready && clr_en && w_sel) begin
                    r_limit <= '0;
                end else if (w_user_we && w_sel && (w_new_limit > r_limit)) begin
                    r_limit <= w_new_limit;
                end
            end

            assign w_limit[gi] = r_limit;
        end
    endgenerate

    assign w_rd_limit = w_limit[proc_sel];
    assign w_in_limit = {1'b0, end_c} < w_rd_limit;

`ifdef INSTR_MEM_BYPASS_EN
    logic                 w_hit;
    logic                 r_byp;
    logic [data_size-1:0] r_byp_data;

    // A matching same-edge write always covers end_c, so the post-write limit passes.
    assign w_hit   = w_user_we && (wr_proc == proc_sel) && (end_save == end_c);
    assign w_fault = !w_proc_ok || !(w_in_limit || w_hit);

    always_ff @(negedge clock_in) begin
        if (reset_in) begin
            r_byp <= 1'b0;
        end else if (w_fetch) begin
            r_byp <= w_hit;
        end
    end

    always_ff @(negedge clock_in) begin
        if (w_fetch) begin
            r_byp_data <= data_in;
        end
    end

    assign instruction_out = r_nop ? NOP_WORD : (r_byp ? r_byp_data : r_rd_data);
`else
    assign w_fault         = !w_proc_ok || !w_in_limit;
    assign instruction_out = r_nop ? NOP_WORD : r_rd_data;
`endif

    assign w_we    = w_boot_we || w_user_we;
    assign w_waddr = w_boot_we ? {proc_w'(0), w_boot_addr} : {wr_proc, end_save};
    assign w_wdata = w_boot_we ? w_boot_data : data_in;

    always_ff @(negedge clock_in) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read-before-write: a same-address write on this edge is not seen here.
    always_ff @(negedge clock_in) begin
        if (w_fetch) begin
            r_rd_data <= r_mem[{proc_sel, end_c}];
        end
    end

    always_ff @(negedge clock_in) begin
        if (reset_in) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_nop   <= 1'b1;
        end else if (w_fetch) begin
            r_valid <= 1'b1;
            r_fault <= w_fault;
            r_nop   <= w_fault;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign instr_valid = r_valid;
    assign fault_out   = r_fault;
    assign ready_out   = w_ready;

endmodule

// File: tb/tb_instr_mem_bank.sv
// Directed bench for instr_mem_bank: fetch expectations go into a scoreboard
// queue when issued and are checked against the registered result.
module tb_instr_mem_bank;

    localparam logic [31:0] NOP = 32'hF800_0000;

    logic        clock_in;
    logic        reset_in;
    logic [1:0]  proc_sel;
    logic [10:0] end_c;
    logic        rd_en;
    logic [31:0] instruction_out;
    logic        instr_valid;
    logic        fault_out;
    logic        wr_en;
    logic [1:0]  wr_proc;
    logic [10:0] end_save;
    logic [31:0] data_in;
    logic        clr_en;
    logic        ready_out;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    instr_mem_bank dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .proc_sel       (proc_sel),
        .end_c          (end_c),
        .rd_en          (rd_en),
        .instruction_out(instruction_out),
        .instr_valid    (instr_valid),
        .fault_out      (fault_out),
        .wr_en          (wr_en),
        .wr_proc        (wr_proc),
        .end_save       (end_save),
        .data_in        (data_in),
        .clr_en         (clr_en),
        .ready_out      (ready_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // One active (falling) edge; compares valid and pops any pending fetch.
    task automatic cycle();
        bit   exp_v;
        exp_t e;
        exp_v = (sb_q.size() != 0);
        @(negedge clock_in);
        #1;
        checks++;
        assert (instr_valid === exp_v) else begin
            failures++;
            $error("FAIL instr_valid: observed=%b expected=%b", instr_valid, exp_v);
        end
        if (exp_v) begin
            e = sb_q.pop_front();
            checks++;
            assert (instruction_out === e.data) else begin
                failures++;
                $error("FAIL %s data: observed=%h expected=%h", e.tag, instruction_out, e.data);
            end
            checks++;
            assert (fault_out === e.fault) else begin
                failures++;
                $error("FAIL %s fault: observed=%b expected=%b", e.tag, fault_out, e.fault);
            end
            $display("fetch %s data=%h fault=%b", e.tag, instruction_out, fault_out);
        end
    endtask

    task automatic op(input string tag, input logic rd, input logic [1:0] rp,
                      input logic [10:0] ra, input logic wr, input logic clr,
                      input logic [1:0] wp, input logic [10:0] wa, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_f);
        proc_sel = rp;  end_c    = ra;  rd_en   = rd;
        wr_en    = wr;  clr_en   = clr; wr_proc = wp;
        end_save = wa;  data_in  = wd;
        if (rd) sb_q.push_back('{tag: tag, data: exp_d, fault: exp_f});
        if (wr || clr)
            $display("op %s write=%b clear=%b bank=%0d addr=%0d data=%h", tag, wr, clr, wp, wa, wd);
        cycle();
        rd_en = 1'b0; wr_en = 1'b0; clr_en = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [1:0] p, input logic [10:0] a,
                         input logic [31:0] exp_d, input logic exp_f);
        op(tag, 1'b1, p, a, 1'b0, 1'b0, 2'd0, 11'd0, 32'd0, exp_d, exp_f);
    endtask

    task automatic write(input string tag, input logic [1:0] p, input logic [10:0] a,
                         input logic [31:0] d);
        op(tag, 1'b0, 2'd0, 11'd0, 1'b1, 1'b0, p, a, d, 32'd0, 1'b0);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Counts falling edges from reset release until ready_out rises (rd_en held high).
    task automatic boot_count(input string tag);
        int n;
        n = 0;
        rd_en = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            cycle();
            if (ready_out === 1'b1) begin
                n = i;
                break;
            end
        end
        rd_en = 1'b0;
        checks++;
        assert (n == 22) else begin
            failures++;
            $error("FAIL %s boot_edges: observed=%0d expected=22", tag, n);
        end
        $display("boot %s ready after %0d edges", tag, n);
    endtask

    initial begin
        reset_in = 1'b1; proc_sel = '0; end_c = '0; rd_en = 1'b0;
        wr_en = 1'b0; wr_proc = '0; end_save = '0; data_in = '0; clr_en = 1'b0;

        cycle();
        cycle();
        check_bit("rst_ready", ready_out, 1'b0);
        check_bit("rst_fault", fault_out, 1'b0);
        check_word("rst_instr", instruction_out, NOP);

        reset_in = 1'b0;
        boot_count("first");
        check_word("boot_instr_nop", instruction_out, NOP);

        fetch("b0_a1", 2'd0, 11'd1, 32'h6040_000C, 1'b0);
        fetch("b0_a22", 2'd0, 11'd22, NOP, 1'b1);

        write("w_b2_a5", 2'd2, 11'd5, 32'h1234_5678);
        fetch("b2_a5", 2'd2, 11'd5, 32'h1234_5678, 1'b0);
        fetch("b2_a6", 2'd2, 11'd6, NOP, 1'b1);
        cycle();
        check_word("hold_nop", instruction_out, NOP);
        check_bit("hold_fault1", fault_out, 1'b1);
        fetch("b2_a5_again", 2'd2, 11'd5, 32'h1234_5678, 1'b0);
        cycle();
        check_word("hold_data", instruction_out, 32'h1234_5678);
        check_bit("hold_fault0", fault_out, 1'b0);

        write("w_b1_a0", 2'd1, 11'd0, 32'hAAAA_0001);
`ifdef INSTR_MEM_BYPASS_EN
        op("raw_b1_a0", 1'b1, 2'd1, 11'd0, 1'b1, 1'b0, 2'd1, 11'd0, 32'hBBBB_0002, 32'hBBBB_0002, 1'b0);
        op("raw_b3_a4", 1'b1, 2'd3, 11'd4, 1'b1, 1'b0, 2'd3, 11'd4, 32'hCCCC_0004, 32'hCCCC_0004, 1'b0);
`else
        op("raw_b1_a0", 1'b1, 2'd1, 11'd0, 1'b1, 1'b0, 2'd1, 11'd0, 32'hBBBB_0002, 32'hAAAA_0001, 1'b0);
        op("raw_b3_a4", 1'b1, 2'd3, 11'd4, 1'b1, 1'b0, 2'd3, 11'd4, 32'hCCCC_0004, NOP, 1'b1);
`endif
        fetch("b1_a0_after", 2'd1, 11'd0, 32'hBBBB_0002, 1'b0);
        fetch("b3_a4_after", 2'd3, 11'd4, 32'hCCCC_0004, 1'b0);

        write("w_b3_top", 2'd3, 11'd2047, 32'hDDDD_07FF);
        fetch("b3_top", 2'd3, 11'd2047, 32'hDDDD_07FF, 1'b0);

        op("clr_wr_b2", 1'b0, 2'd0, 11'd0, 1'b1, 1'b1, 2'd2, 11'd0, 32'hEEEE_0000, 32'd0, 1'b0);
        fetch("b2_a0_clr", 2'd2, 11'd0, NOP, 1'b1);
        fetch("b2_a5_clr", 2'd2, 11'd5, NOP, 1'b1);

        op("clr_b0", 1'b0, 2'd0, 11'd0, 1'b0, 1'b1, 2'd0, 11'd0, 32'd0, 32'd0, 1'b0);
        fetch("b0_a1_clr", 2'd0, 11'd1, NOP, 1'b1);

        op("clr_b1", 1'b0, 2'd0, 11'd0, 1'b0, 1'b1, 2'd1, 11'd0, 32'd0, 32'd0, 1'b0);
        write("w_b1_a3", 2'd1, 11'd3, 32'h1111_0003);
        fetch("b1_a0_kept", 2'd1, 11'd0, 32'hBBBB_0002, 1'b0);

        reset_in = 1'b1;
        cycle();
        check_bit("midrst_ready", ready_out, 1'b0);
        check_bit("midrst_fault", fault_out, 1'b0);
        check_word("midrst_instr", instruction_out, NOP);
        reset_in = 1'b0;
        boot_count("rerun");
        fetch("b2_a5_rst", 2'd2, 11'd5, NOP, 1'b1);
        fetch("b0_a1_rst", 2'd0, 11'd1, 32'h6040_000C, 1'b0);

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_bank.md
Name: instr_mem_bank

Overview:
- Parametrised, writable instruction memory holding one program bank per process. Successor to the fixed single-image boot ROM.
- After reset, a boot FSM copies the built-in boot image into bank 0. The OS can then load further process programs through a write port, for example from hdload/storeso data.
- Sits between the fetch stage (end_c address) and the OS loader (end_save write address).

Parameters:
- data_size, 32, instruction word width
- memory_size, 11, address width per bank (DEPTH = 2**memory_size words)
- num_proc, 4, number of process banks (at least 2)
- proc_w, 2, width of process selectors (clog2 of num_proc)
- boot_len, 22, number of boot image words copied to bank 0 (at most DEPTH)

Ports:
- clock_in, input, 1, system clock; all state updates on negedge of clock_in
- reset_in, input, 1, synchronous active-high reset, sampled on negedge of clock_in
- proc_sel, input, proc_w, bank used for fetch
- end_c, input, memory_size, fetch address
- rd_en, input, 1, fetch request
- instruction_out, output, data_size, registered fetched word
- instr_valid, output, 1, instruction_out holds a fresh fetch result
- fault_out, output, 1, last fetch was outside the bank limit or hit an invalid bank
- wr_en, input, 1, write request
- wr_proc, input, proc_w, bank being written
- end_save, input, memory_size, write address
- data_in, input, data_size, write data
- clr_en, input, 1, clears the limit of bank wr_proc
- ready_out, output, 1, boot image copied; memory accepts fetches and writes

Behaviour:
- Reset values:
  - instruction_out = NOP (32'hF800_0000)
  - instr_valid = 0, fault_out = 0, ready_out = 0
  - all bank limits = 0
  - FSM enters BOOT with copy index = 0
  - Memory array contents are not reset.
- FSM state BOOT:
  - Each negedge writes boot_image[idx] to bank 0 at address idx, then idx increments.
  - When idx reaches boot_len-1, the FSM moves to READY after that write, and limit[0] = boot_len.
  - In BOOT, rd_en, wr_en and clr_en are ignored; instruction_out = NOP and instr_valid = 0.
- FSM state READY:
  - ready_out = 1.
  - The FSM stays in READY until reset_in.
- Fetch (1-cycle latency):
  - rd_en is sampled at negedge N; the result appears after negedge N and instr_valid = 1 for one cycle.
  - If proc_sel >= num_proc or end_c >= limit[proc_sel]: instruction_out = NOP and fault_out = 1.
  - Otherwise: instruction_out = mem[proc_sel][end_c] and fault_out = 0.
  - When rd_en = 0: instr_valid = 0, and instruction_out and fault_out hold their previous values.
- Write:
  - On wr_en in READY with wr_proc < num_proc: mem[wr_proc][end_save] = data_in.
  - The same edge sets limit[wr_proc] = max(limit, end_save+1). The limit saturates at DEPTH, so the limit register is memory_size+1 bits wide.
  - wr_proc >= num_proc: the write is dropped silently.
- Clear:
  - clr_en sets limit[wr_proc] = 0; the data is left untouched.
  - If clr_en and wr_en arrive together, the clear takes priority and the write is dropped.
  - A clear of bank 0 is allowed; it disables BIOS fetch until bank 0 is rewritten.
- Simultaneous read and write to the same bank and address (no bypass): the fetch returns the old word. The limit check uses the pre-write limit.
- reset_in mid-BOOT or mid-READY: the FSM restarts BOOT at the next negedge and all limits return to 0.

Optional Feature:
- Macro: INSTR_MEM_BYPASS_EN.
- Defined: a same-edge write and fetch to an identical bank and address returns data_in, and the limit check uses the updated limit. This gives read-after-write forwarding for the OS loader.
- Undefined: the fetch returns the old contents, as described in Behaviour.

Decomposition:
- Package instr_mem_pkg holds:
  - NOP_INSTR constant (32'hF800_0000)
  - the boot_image constant array (boot_len words: process-output sequence, SO/SOi setup, hdload/storeso copy loop)
  - the FSM state enum {BOOT, READY}
- Sub-module instr_mem_boot_fsm contains the copy index, state register, boot write-enable/address/data mux and ready_out.
- The bank array, limit registers and fetch logic live in the top module.

Test Plan:
- Reset for 2 cycles, then release -> ready_out rises after exactly 22 negedges. Fetch bank 0 address 1 -> 32'h6040_000C, valid one cycle later, fault_out = 0.
- Fetch bank 0 address 22 after boot -> instruction_out = 32'hF800_0000, fault_out = 1.
- Write bank 2 address 5 = 32'h1234_5678 -> limit[2] = 6. Fetch bank 2 address 5 returns 32'h1234_5678; fetch address 6 faults.
- Write and fetch bank 1 address 0 on the same edge -> old data without INSTR_MEM_BYPASS_EN; data_in with it.
- clr_en on bank 2 together with wr_en -> the write is dropped and a fetch of bank 2 address 0 faults. rd_en during BOOT -> instr_valid stays 0.
- Assert reset_in mid-READY, then fetch bank 2 -> fault_out = 1 and the boot copy reruns (22 cycles until ready_out).
